// File: rtl/div32_seq_if.sv
// Operand-issue and writeback handshakes for the sequential divider.
// The master drives operands and accepts results; the slave is the divider.
interface div32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Sequential unsigned 32-bit restoring divider, one quotient bit per cycle.
// Trial subtraction runs through a 32-bit ripple-carry adder (t + ~d + 1).
module fa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  div32_seq_if.slave  io
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q, r, d;
  logic [4:0]       cnt;
  logic             dz;

  logic [WIDTH-1:0] t, sum;
  logic             cout;

  // r < 2^31 before every shift, so t never loses a bit
  assign t = {r[WIDTH-2:0], q[WIDTH-1]};

  fa32 u_add (
    .a    (t),
    .b    (~d),
    .cin  (1'b1),
    .sum  (sum),
    .cout (cout)
  );

  assign io.in_ready    = (state == IDLE);
  assign io.out_valid   = (state == DONE);
  assign io.quotient    = q;
  assign io.remainder   = r;
  assign io.div_by_zero = dz;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (io.in_valid)
              state_nx = (io.divisor == '0) ? DONE : BUSY;
      BUSY: if (cnt == 5'd0)
              state_nx = DONE;
      DONE: if (io.out_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            if (io.divisor == '0) begin
              q  <= '1;
              r  <= io.dividend;
              dz <= 1'b1;
            end else begin
              q   <= io.dividend;
              r   <= '0;
              d   <= io.divisor;
              cnt <= 5'd31;
              dz  <= 1'b0;
            end
          end
        end
        BUSY: begin
          r   <= cout ? sum : t;
          q   <= {q[WIDTH-2:0], cout};
          cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
